// File: rtl/wide_add_sequencer.sv
// Wide add/subtract sequencer: feeds a W = 32*WORDS bit operation through one
// shared 32-bit ripple adder, one word per cycle, least-significant word first,
// with the inter-word carry held in a register.

// 32-bit ripple-carry adder used as the shared word datapath.
module adder_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [32:0] carry;

  // Bit-serial ripple: each bit's carry feeds the next within this word only.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < 32; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = carry[32];

endmodule

module wide_add_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic [32*WORDS-1:0]   a,
  input  logic [32*WORDS-1:0]   b,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [32*WORDS-1:0]   result,
  output logic                  cout,
  output logic                  ovf
);

  localparam int W  = 32 * WORDS;
  localparam int KW = $clog2(WORDS);
  localparam logic [KW-1:0] LAST_K = KW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [W-1:0]  opa;
  logic [W-1:0]  opb;
  logic          carry;
  logic [KW-1:0] k;

  logic [31:0]   word_a;
  logic [31:0]   word_b;
  logic [31:0]   word_sum;
  logic          word_cout;

  // Current word of the latched operands; opb already holds ~b for subtraction.
  assign word_a = opa[k*32 +: 32];
  assign word_b = opb[k*32 +: 32];

  adder_32bit u_adder (
    .a    (word_a),
    .b    (word_b),
    .cin  (carry),
    .sum  (word_sum),
    .cout (word_cout)
  );

  // Handshake flags are pure state decodes so reset clears them immediately.
  assign ready = (state == IDLE);
  assign busy  = (state == RUN);
  assign done  = (state == DONE);

  // Control FSM plus word-by-word result, carry chain and final flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      opa    <= '0;
      opb    <= '0;
      carry  <= 1'b0;
      k      <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= sub;
            k     <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          result[k*32 +: 32] <= word_sum;
          carry              <= word_cout;
          k                  <= k + 1'b1;
          if (k == LAST_K) begin
            cout  <= word_cout;
            ovf   <= (opa[W-1] == opb[W-1]) & (word_sum[31] != opa[W-1]);
            k     <= '0;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer (WORDS=4): directed corner cases,
// randomized ops against an arithmetic reference model, continuous-start
// throughput, and asynchronous reset / abort behaviour.

module tb_wide_add_sequencer;

  localparam int WORDS = 4;
  localparam int W     = 32 * WORDS;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  int errors = 0;
  int checks = 0;

  wide_add_sequencer #(.WORDS(WORDS)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: whole-width arithmetic; returns {ovf, cout, result}.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic ms);
    logic [W:0] full;
    logic       c;
    logic       o;
    if (!ms) begin
      full = {1'b0, ma} + {1'b0, mb};
      c    = full[W];
      o    = (ma[W-1] == mb[W-1]) && (full[W-1] != ma[W-1]);
    end else begin
      full = {1'b0, ma} - {1'b0, mb};
      c    = (ma >= mb);
      o    = (ma[W-1] != mb[W-1]) && (full[W-1] != ma[W-1]);
    end
    return {o, c, full[W-1:0]};
  endfunction

  function automatic logic [W-1:0] rand_wide();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Launch one op from IDLE and wait (bounded) for done; lat=-1 on timeout.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic ts,
                        output int lat);
    @(negedge clk);
    a = ta; b = tb2; sub = ts; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = rand_wide(); b = rand_wide(); sub = $urandom_range(0, 1);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [W-1:0] junk;
    int lat;
    junk = rand_wide();
    run_op(junk, rand_wide(), 1'b0, lat);
    // Now in DONE with non-zero result most likely; reset between edges.
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({ready, busy, done, cout, ovf} !== 5'b10000) begin
      errors++;
      $display("[TB] FAIL reset_flags actual=%b required=10000", {ready, busy, done, cout, ovf});
    end
    checks++;
    if (result !== '0) begin
      errors++;
      $display("[TB] FAIL reset_result actual=%h required=0", result);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [W-1:0] va[6];
    logic [W-1:0] vb[6];
    logic         vs[6];
    logic [W-1:0] er[6];
    logic         ec[6];
    logic         eo[6];
    int lat;
    va[0] = {32'h0, {96{1'b1}}};  vb[0] = 1; vs[0] = 0;
    er[0] = {32'h1, 96'h0};       ec[0] = 0; eo[0] = 0;
    va[1] = {W{1'b1}};            vb[1] = 1; vs[1] = 0;
    er[1] = '0;                   ec[1] = 1; eo[1] = 0;
    va[2] = {1'b0, {(W-1){1'b1}}}; vb[2] = 1; vs[2] = 0;
    er[2] = {1'b1, {(W-1){1'b0}}}; ec[2] = 0; eo[2] = 1;
    va[3] = '0;                   vb[3] = 1; vs[3] = 1;
    er[3] = {W{1'b1}};            ec[3] = 0; eo[3] = 0;
    va[4] = 5;                    vb[4] = 3; vs[4] = 1;
    er[4] = 2;                    ec[4] = 1; eo[4] = 0;
    va[5] = {1'b1, {(W-1){1'b0}}}; vb[5] = 1; vs[5] = 1;
    er[5] = {1'b0, {(W-1){1'b1}}}; ec[5] = 1; eo[5] = 1;
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], vs[i], lat);
      checks++;
      if (lat !== 4) begin
        errors++;
        $display("[TB] FAIL dir%0d_latency actual=%0d required=4", i, lat);
      end
      checks++;
      if ({result, cout, ovf} !== {er[i], ec[i], eo[i]}) begin
        errors++;
        $display("[TB] FAIL dir%0d_result actual=%h c%b o%b required=%h c%b o%b",
                 i, result, cout, ovf, er[i], ec[i], eo[i]);
      end
      checks++;
      if ({ready, busy} !== 2'b00) begin
        errors++;
        $display("[TB] FAIL dir%0d_done_flags actual=%b required=00", i, {ready, busy});
      end
      @(negedge clk);
      checks++;
      if ({ready, busy, done} !== 3'b100 || {result, cout, ovf} !== {er[i], ec[i], eo[i]}) begin
        errors++;
        $display("[TB] FAIL dir%0d_hold actual=%b %h required=100 %h",
                 i, {ready, busy, done}, result, er[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ta, tb2;
    logic         ts;
    logic [W+1:0] exp;
    int lat;
    for (int i = 0; i < 12; i++) begin
      ta = rand_wide(); tb2 = rand_wide(); ts = $urandom_range(0, 1);
      if (i == 0) tb2 = ta;
      exp = model(ta, tb2, ts);
      run_op(ta, tb2, ts, lat);
      checks++;
      if (lat !== 4 || {ovf, cout, result} !== exp) begin
        errors++;
        $display("[TB] FAIL rand%0d actual=lat%0d o%b c%b %h required=lat4 o%b c%b %h",
                 i, lat, ovf, cout, result, exp[W+1], exp[W], exp[W-1:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W+1:0] q[$];
    logic [W+1:0] exp;
    int cyc;
    int last_acc;
    int accepts;
    @(negedge clk);
    last_acc = -1;
    accepts  = 0;
    start    = 1'b1;
    for (cyc = 0; cyc < 40; cyc++) begin
      if (done) begin
        exp = (q.size() > 0) ? q.pop_front() : '0;
        checks++;
        if ({ovf, cout, result} !== exp) begin
          errors++;
          $display("[TB] FAIL b2b_result cyc%0d actual=%h required=%h", cyc, result, exp[W-1:0]);
        end
      end
      a = rand_wide(); b = rand_wide(); sub = $urandom_range(0, 1);
      if (ready) begin
        q.push_back(model(a, b, sub));
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc !== 6) begin
            errors++;
            $display("[TB] FAIL b2b_interval actual=%0d required=6", cyc - last_acc);
          end
        end
        last_acc = cyc;
        accepts++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    start = 1'b0;
    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      if (done) begin
        exp = q.pop_front();
        checks++;
        if ({ovf, cout, result} !== exp) begin
          errors++;
          $display("[TB] FAIL b2b_tail actual=%h required=%h", result, exp[W-1:0]);
        end
      end
      if (q.size() > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    checks++;
    if (q.size() !== 0 || accepts < 6) begin
      errors++;
      $display("[TB] FAIL b2b_count actual=pending%0d accepts%0d required=pending0 accepts>=6",
               q.size(), accepts);
    end
  endtask

  task automatic test_abort();
    logic [W-1:0] ta, tb2;
    logic [W+1:0] exp;
    int seen_done;
    int lat;
    @(negedge clk);
    a = rand_wide(); b = rand_wide(); sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_busy actual=%b required=1", busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({ready, busy, done, cout, ovf} !== 5'b10000 || result !== '0) begin
      errors++;
      $display("[TB] FAIL abort_reset actual=%b %h required=10000 0",
               {ready, busy, done, cout, ovf}, result);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    checks++;
    if (seen_done !== 0) begin
      errors++;
      $display("[TB] FAIL abort_no_done actual=%0d required=0", seen_done);
    end
    ta = rand_wide(); tb2 = rand_wide();
    exp = model(ta, tb2, 1'b1);
    run_op(ta, tb2, 1'b1, lat);
    checks++;
    if (lat !== 4 || {ovf, cout, result} !== exp) begin
      errors++;
      $display("[TB] FAIL abort_recover actual=lat%0d %h required=lat4 %h",
               lat, result, exp[W-1:0]);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    #12;
    checks++;
    if ({ready, busy, done, cout, ovf} !== 5'b10000 || result !== '0) begin
      errors++;
      $display("[TB] FAIL init_reset actual=%b %h required=10000 0",
               {ready, busy, done, cout, ovf}, result);
    end
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
